// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet width, output-arbiter state and the round-robin
// pick function used by the router output ports and the PE-side NIC.
package noc_pkg;

  localparam int unsigned DEFAULT_PACKET_WIDTH = 64;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  // One-hot grant of the first set request at or after ptr, wrapping at n (n <= 8).
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      idx = (32'(ptr) + off) % n;
      if (off < n && !found && req[3'(idx)]) begin
        pick[3'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate: one-hot grant plus its binary index.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    gnt_idx
);

  always_comb begin
    gnt = '0;
    if (enable) begin
      gnt = NUM_REQ'(rr_pick(8'(req), 3'(ptr), NUM_REQ));
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output channel of a router: round-robin grant among input buffers into a
// single-entry output register with a send/ready downstream handshake.
module router_out_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int unsigned NUM_REQ      = 4,
  localparam int unsigned IdxW        = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic                            so,
  input  logic                            ro,
  output logic [PACKET_WIDTH-1:0]         dout,
  output logic                            busy
);

  arb_state_t              state_q;
  logic [PACKET_WIDTH-1:0] do_q;
  logic [IdxW-1:0]         ptr_q;

  logic            can_load;
  logic            grant;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] ptr_next;

  // A full register that is draining this edge can accept a new packet without a bubble.
  assign can_load = (state_q == EMPTY) | ro;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_q),
    .enable  (can_load & reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant    = |gnt;
  assign ptr_next = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      do_q    <= '0;
      ptr_q   <= '0;
    end else begin
      if (grant) begin
        state_q <= FULL;
        do_q    <= req_data[gnt_idx*PACKET_WIDTH +: PACKET_WIDTH];
        ptr_q   <= ptr_next;
      end else if (state_q == FULL && ro) begin
        state_q <= EMPTY;
      end
    end
  end

  assign so   = (state_q == FULL);
  assign busy = (state_q == FULL);
  assign dout = do_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: reset, round-robin order, stall, pointer
// wrap, single packet drain and asynchronous reset while holding a packet.
module tb_router_out_arbiter;

  localparam int unsigned PW = 64;
  localparam int unsigned NR = 4;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req;
  logic [NR*PW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic             so;
  logic             ro;
  logic [PW-1:0]    dout;
  logic             busy;

  int vectors;
  int miscompares;

  router_out_arbiter #(
    .PACKET_WIDTH (PW),
    .NUM_REQ      (NR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .so       (so),
    .ro       (ro),
    .dout     (dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pkt(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i + 1) * 64'h0000_0000_0101_0011;
  endfunction

  task automatic load_default_data();
    for (int i = 0; i < NR; i++) req_data[i*PW +: PW] = pkt(i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    ro    = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    load_default_data();
    reset = 1'b0;
    req   = 4'b1111;
    ro    = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0000) begin
      $display("FAIL reset_gnt: got %b want 0000", gnt); miscompares++;
    end
    vectors++;
    if (so !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_so: got so=%b busy=%b want 0/0", so, busy); miscompares++;
    end
    vectors++;
    if (dout !== 64'h0) begin
      $display("FAIL reset_do: got %h want 0", dout); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0000) begin
      $display("FAIL reset_gnt_held: got %b want 0000", gnt); miscompares++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin
      $display("FAIL release_gnt: got %b want 0001", gnt); miscompares++;
    end
    @(negedge clk);
    req = '0;
    vectors++;
    if (so !== 1'b1 || dout !== pkt(0)) begin
      $display("FAIL release_out: got so=%b do=%h want 1 %h", so, dout, pkt(0));
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    load_default_data();
    do_reset();
    req = 4'b1111;
    ro  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (gnt !== 4'(1 << exp_order[i])) begin
        $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, 4'(1 << exp_order[i]));
        miscompares++;
      end
      if (i > 0) begin
        vectors++;
        if (so !== 1'b1 || dout !== pkt(exp_order[i-1])) begin
          $display("FAIL rr_out[%0d]: got so=%b do=%h want 1 %h", i, so, dout,
                   pkt(exp_order[i-1]));
          miscompares++;
        end
      end
      @(negedge clk);
    end
    req = '0;
    #1;
    vectors++;
    if (so !== 1'b1 || dout !== pkt(0) || gnt !== 4'b0000) begin
      $display("FAIL rr_last: got so=%b do=%h gnt=%b want 1 %h 0000", so, dout, gnt, pkt(0));
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (so !== 1'b0) begin
      $display("FAIL rr_drain: got so=%b want 0", so); miscompares++;
    end
  endtask

  task automatic test_stall();
    load_default_data();
    req_data[0*PW +: PW] = 64'hA5;
    do_reset();
    req = 4'b0001;
    ro  = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    ro  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (so !== 1'b1 || busy !== 1'b1 || dout !== 64'hA5 || gnt !== 4'b0000) begin
        $display("FAIL stall[%0d]: got so=%b busy=%b do=%h gnt=%b want 1 1 a5 0000",
                 i, so, busy, dout, gnt);
        miscompares++;
      end
      @(negedge clk);
    end
    ro = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0100 || so !== 1'b1) begin
      $display("FAIL stall_release: got gnt=%b so=%b want 0100 1", gnt, so); miscompares++;
    end
    @(negedge clk);
    req = '0;
    vectors++;
    if (so !== 1'b1 || dout !== pkt(2)) begin
      $display("FAIL stall_next: got so=%b do=%h want 1 %h", so, dout, pkt(2));
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    load_default_data();
    do_reset();
    req = 4'b1000;
    ro  = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b1000) begin
      $display("FAIL wrap_gnt3: got %b want 1000", gnt); miscompares++;
    end
    @(negedge clk);
    req = 4'b1001;
    #1;
    vectors++;
    if (gnt !== 4'b0001) begin
      $display("FAIL wrap_gnt0: got %b want 0001", gnt); miscompares++;
    end
    @(negedge clk);
    #1;
    vectors++;
    if (gnt !== 4'b1000 || dout !== pkt(0)) begin
      $display("FAIL wrap_after: got gnt=%b do=%h want 1000 %h", gnt, dout, pkt(0));
      miscompares++;
    end
    @(negedge clk);
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    load_default_data();
    do_reset();
    req = 4'b0010;
    ro  = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0010) begin
      $display("FAIL single_gnt: got %b want 0010", gnt); miscompares++;
    end
    @(negedge clk);
    req = '0;
    vectors++;
    if (so !== 1'b1 || dout !== pkt(1)) begin
      $display("FAIL single_out: got so=%b do=%h want 1 %h", so, dout, pkt(1));
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (so !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL single_empty: got so=%b busy=%b want 0 0", so, busy); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (so !== 1'b0 || gnt !== 4'b0000) begin
      $display("FAIL single_idle: got so=%b gnt=%b want 0 0000", so, gnt); miscompares++;
    end
  endtask

  task automatic test_async_reset();
    load_default_data();
    do_reset();
    req = 4'b0100;
    ro  = 1'b0;
    @(negedge clk);
    req = '0;
    vectors++;
    if (so !== 1'b1 || dout !== pkt(2)) begin
      $display("FAIL areset_loaded: got so=%b do=%h want 1 %h", so, dout, pkt(2));
      miscompares++;
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (so !== 1'b0 || busy !== 1'b0 || dout !== 64'h0) begin
      $display("FAIL areset_async: got so=%b busy=%b do=%h want 0 0 0", so, busy, dout);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    ro    = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0000) begin
      $display("FAIL areset_nogrant: got %b want 0000", gnt); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (so !== 1'b0) begin
      $display("FAIL areset_idle: got so=%b want 0", so); miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    req         = '0;
    ro          = 1'b1;
    req_data    = '0;
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_single();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
